// File: rtl/mux_8to1_rr_arbiter_if.sv
// Bundles the requester side of the 8:1 arbitrated one-bit mux.
// Latency: none here; pure signal grouping.
// Backpressure: none; requesters observe gnt/valid to know when they own the mux.
//
// Ports (slave = arbiter view):
//   req   in  8  per-requester request, index 0..7
//   D     in  8  per-requester data bit
//   S     out 3  registered select of current grantee
//   gnt   out 8  registered one-hot grant, 0 when idle
//   valid out 1  registered, 1 while a grant is active
//   Y     out 1  combinational routed data bit
interface mux_8to1_rr_arbiter_if;
    logic [7:0] req;
    logic [7:0] D;
    logic [2:0] S;
    logic [7:0] gnt;
    logic       valid;
    logic       Y;

    modport slave (
        input  req,
        input  D,
        output S,
        output gnt,
        output valid,
        output Y
    );

    modport master (
        output req,
        output D,
        input  S,
        input  gnt,
        input  valid,
        input  Y
    );
endinterface

// File: rtl/mux_8to1_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 8:1 one-bit mux; Y = D[S] while granted.
// Latency: req -> gnt/S/valid 1 clk (registered); D -> Y combinational within the cycle.
// Backpressure: a grantee keeps the mux while requesting, for at most MAX_HOLD cycles if others wait.
//
// Ports:
//   clk  in  single clock, all state updates on posedge
//   rst  in  asynchronous active-high reset
//   bus  slave modport of mux_8to1_rr_arbiter_if (req, D in; S, gnt, valid, Y out)
// MAX_HOLD must lie in 1..2**CNT_W-1.
module mux_8to1_rr_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    mux_8to1_rr_arbiter_if.slave         bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [2:0]         s_q, s_n;
    logic [7:0]         gnt_q, gnt_n;
    logic               valid_q, valid_n;
    logic [CNT_W-1:0]   hold_cnt, hold_n;
    logic [2:0]         last_ptr, last_n;

    logic [3:0]         pick_idle;   // {found, index}
    logic [3:0]         pick_other;  // {found, index}
    logic               hold_expired;

    // Scan base+1, base+2, ... modulo 8 and return the first active request.
    // The base itself is only considered (as the final candidate) when incl_base is set,
    // which lets the same scan serve both the idle search and the "someone else" search.
    function automatic logic [3:0] rr_pick(input logic [7:0] r,
                                           input logic [2:0] base,
                                           input logic       incl_base);
        logic       found;
        logic [2:0] win;
        logic [2:0] idx;
        found = 1'b0;
        win   = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            idx = base + 3'(k);
            if (!found && r[idx] && (k < 8 || incl_base)) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    assign pick_idle    = rr_pick(bus.req, last_ptr, 1'b1);
    assign pick_other   = rr_pick(bus.req, s_q, 1'b0);
    assign hold_expired = (hold_cnt == CNT_W'(MAX_HOLD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            s_q      <= 3'd0;
            gnt_q    <= 8'd0;
            valid_q  <= 1'b0;
            hold_cnt <= '0;
            last_ptr <= 3'd7;
        end else begin
            state    <= state_n;
            s_q      <= s_n;
            gnt_q    <= gnt_n;
            valid_q  <= valid_n;
            hold_cnt <= hold_n;
            last_ptr <= last_n;
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s_q;
        gnt_n   = gnt_q;
        valid_n = valid_q;
        hold_n  = hold_cnt;
        last_n  = last_ptr;

        unique case (state)
            IDLE: begin
                if (pick_idle[3]) begin
                    state_n = GRANT;
                    s_n     = pick_idle[2:0];
                    gnt_n   = 8'b1 << pick_idle[2:0];
                    valid_n = 1'b1;
                    hold_n  = CNT_W'(1);
                    last_n  = pick_idle[2:0];
                end
            end

            GRANT: begin
                if (!bus.req[s_q]) begin
                    if (pick_other[3]) begin
                        // Hand straight over to the next requester without an idle cycle.
                        s_n    = pick_other[2:0];
                        gnt_n  = 8'b1 << pick_other[2:0];
                        hold_n = CNT_W'(1);
                        last_n = pick_other[2:0];
                    end else begin
                        // S keeps its last value so the mux select does not glitch.
                        state_n = IDLE;
                        gnt_n   = 8'd0;
                        valid_n = 1'b0;
                        hold_n  = '0;
                    end
                end else if (hold_expired) begin
                    if (pick_other[3]) begin
                        s_n    = pick_other[2:0];
                        gnt_n  = 8'b1 << pick_other[2:0];
                        hold_n = CNT_W'(1);
                        last_n = pick_other[2:0];
                    end else begin
                        // Nobody waiting: renew the same grant for another hold window.
                        hold_n = CNT_W'(1);
                    end
                end else begin
                    hold_n = hold_cnt + CNT_W'(1);
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.S     = s_q;
    assign bus.gnt   = gnt_q;
    assign bus.valid = valid_q;
    assign bus.Y     = valid_q ? bus.D[s_q] : 1'b0;

endmodule

// File: tb/tb_mux_8to1_rr_arbiter.sv
// Bench for the round-robin 8:1 mux arbiter: directed vectors, an integer-level reference
// model updated on each clock edge, and a negedge compare process against that model.
module tb_mux_8to1_rr_arbiter;

    localparam int MAX_HOLD = 4;

    logic clk;
    logic rst;

    mux_8to1_rr_arbiter_if bus ();

    mux_8to1_rr_arbiter #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_valid;   // 1 when someone owns the mux
    int m_s;       // owner index (kept after going idle)
    int m_hold;    // cycles the current owner has held
    int m_last;    // most recent owner, start of the next idle search

    // First requester after 'base' in circular order; base itself last if allowed.
    function automatic int next_req(input logic [7:0] r, input int base, input bit incl_base);
        for (int k = 1; k <= 8; k++) begin
            int idx;
            idx = (base + k) % 8;
            if (k == 8 && !incl_base) return -1;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 0;
            m_s     = 0;
            m_hold  = 0;
            m_last  = 7;
        end else begin
            int w;
            if (m_valid == 0) begin
                w = next_req(bus.req, m_last, 1'b1);
                if (w >= 0) begin
                    m_valid = 1; m_s = w; m_hold = 1; m_last = w;
                end
            end else begin
                w = next_req(bus.req, m_s, 1'b0);
                if (!bus.req[m_s]) begin
                    if (w >= 0) begin
                        m_s = w; m_hold = 1; m_last = w;
                    end else begin
                        m_valid = 0; m_hold = 0;
                    end
                end else if (m_hold == MAX_HOLD) begin
                    if (w >= 0) begin
                        m_s = w; m_last = w;
                    end
                    m_hold = 1;
                end else begin
                    m_hold = m_hold + 1;
                end
            end
        end
    end

    // Outputs are stable mid-cycle; compare on the falling edge.
    always @(negedge clk) begin
        chk("model_S",     int'(bus.S),     m_s);
        chk("model_gnt",   int'(bus.gnt),   m_valid ? (1 << m_s) : 0);
        chk("model_valid", int'(bus.valid), m_valid);
        chk("model_Y",     int'(bus.Y),     m_valid ? int'(bus.D[m_s]) : 0);
    end

    // ---------------- stimulus ----------------
    // Inputs change 2 time units after a rising edge, well clear of both edges.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        bus.req = 8'h00;
        bus.D   = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        // T1: idle after reset
        for (int i = 0; i < 5; i++) tick();
        chk("t1_valid", int'(bus.valid), 0);
        chk("t1_gnt",   int'(bus.gnt),   0);
        chk("t1_S",     int'(bus.S),     0);
        chk("t1_Y",     int'(bus.Y),     0);

        // T2: single requester 2
        bus.req = 8'b0000_0100;
        bus.D   = 8'h04;
        tick();
        chk("t2_S",     int'(bus.S),     2);
        chk("t2_gnt",   int'(bus.gnt),   8'h04);
        chk("t2_valid", int'(bus.valid), 1);
        chk("t2_Y",     int'(bus.Y),     1);
        for (int i = 0; i < 9; i++) tick();
        chk("t2_hold_S", int'(bus.S), 2);
        bus.D = 8'hFB;
        #1;
        chk("t2_Y_follows_D", int'(bus.Y), 0);
        bus.D = 8'h04;

        // T3: all requesting, rotation every MAX_HOLD cycles from 0
        do_reset();
        bus.req = 8'hFF;
        bus.D   = 8'h55;
        for (int n = 1; n <= 36; n++) begin
            tick();
            chk("t3_S", int'(bus.S), ((n - 1) / 4) % 8);
        end

        // T4: grantee 5 drops while 1 waits -> direct switch, fresh hold window
        do_reset();
        bus.req = 8'h20;
        tick();
        chk("t4_S_start", int'(bus.S), 5);
        bus.req = 8'h02;
        tick();
        chk("t4_S_switch", int'(bus.S),     1);
        chk("t4_valid",    int'(bus.valid), 1);
        bus.req = 8'h22;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_S_hold", int'(bus.S), 1);
        end
        tick();
        chk("t4_S_rotate", int'(bus.S), 5);

        // T5: lone requester 3 drops then re-raises
        do_reset();
        bus.req = 8'h08;
        tick();
        chk("t5_S", int'(bus.S), 3);
        bus.req = 8'h00;
        tick();
        chk("t5_idle_valid", int'(bus.valid), 0);
        chk("t5_idle_gnt",   int'(bus.gnt),   0);
        chk("t5_idle_S",     int'(bus.S),     3);
        bus.req = 8'h08;
        tick();
        chk("t5_regrant_S",   int'(bus.S),     3);
        chk("t5_regrant_gnt", int'(bus.gnt),   8'h08);

        // T6: asynchronous reset mid-grant
        do_reset();
        bus.req = 8'hFF;
        bus.D   = 8'hFF;
        tick();
        tick();
        chk("t6_pre_Y", int'(bus.Y), 1);
        rst = 1'b1;
        #1;
        chk("t6_async_gnt",   int'(bus.gnt),   0);
        chk("t6_async_valid", int'(bus.valid), 0);
        chk("t6_async_Y",     int'(bus.Y),     0);
        chk("t6_async_S",     int'(bus.S),     0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_first_S",   int'(bus.S),   0);
        chk("t6_first_gnt", int'(bus.gnt), 8'h01);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
